// File: rtl/hilo_acc_unit_if.sv
// Bus between the execute/multiply stage and the HI/LO accumulate unit.
// The master is the pipeline (requester); the slave is hilo_acc_unit.
interface hilo_acc_unit_if #(
  parameter int unsigned DW = 32
);
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op;
  logic          we_hi;
  logic          we_lo;
  logic [DW-1:0] hi_i;
  logic [DW-1:0] lo_i;
  logic          flush;
  logic [DW-1:0] hi_o;
  logic [DW-1:0] lo_o;
  logic          done;

  modport master (
    output op_valid, op, we_hi, we_lo, hi_i, lo_i, flush,
    input  op_ready, hi_o, lo_o, done
  );

  modport slave (
    input  op_valid, op, we_hi, we_lo, hi_i, lo_i, flush,
    output op_ready, hi_o, lo_o, done
  );
endinterface

// File: rtl/hilo_acc_unit.sv
// HI/LO special-register unit: split MTHI/MTLO writes plus a two-cycle
// {HI,LO} +/- operand accumulate. The low half and its carry are computed
// on acceptance; the high half is folded in on the commit edge so both
// halves become architecturally visible together.
module hilo_acc_unit #(
  parameter int unsigned    DW     = 32,
  parameter logic [DW-1:0]  RST_HI = '0,
  parameter logic [DW-1:0]  RST_LO = '0
) (
  input logic              clk,
  input logic              rst,     // asynchronous, active-low
  hilo_acc_unit_if.slave   bus
);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;

  typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_tmp_hi;
  logic [DW-1:0] r_tmp_lo;
  logic          r_tmp_c;
  logic          r_done;

  logic          w_ready;
  logic          w_accept;
  logic          w_start_acc;
  logic          w_commit;
  logic          w_wr_hi;
  logic          w_wr_lo;
  logic          w_sub;
  logic [DW-1:0] w_lo_opnd;
  logic [DW-1:0] w_hi_opnd;
  logic [DW:0]   w_lo_sum;
  logic [DW-1:0] w_hi_sum;

  // Ready depends only on the state register, never on inputs.
  assign w_ready  = (r_state == S_IDLE);
  assign w_accept = bus.op_valid & w_ready & ~bus.flush;

  // Subtraction is two's complement: invert the operand and inject a
  // carry-in of one into the low half.
  assign w_sub     = (bus.op == OP_SUB);
  assign w_lo_opnd = w_sub ? ~bus.lo_i : bus.lo_i;
  assign w_hi_opnd = w_sub ? ~bus.hi_i : bus.hi_i;
  assign w_lo_sum  = {1'b0, r_lo} + {1'b0, w_lo_opnd} + {{DW{1'b0}}, w_sub};
  assign w_hi_sum  = r_hi + r_tmp_hi + {{(DW-1){1'b0}}, r_tmp_c};

  // Next-state and per-cycle control; op 11 is accepted but does nothing.
  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_commit     = 1'b0;
    w_wr_hi      = 1'b0;
    w_wr_lo      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (bus.op == OP_WRITE) begin
            w_wr_hi = bus.we_hi;
            w_wr_lo = bus.we_lo;
          end else if (bus.op == OP_ADD || bus.op == OP_SUB) begin
            w_start_acc  = 1'b1;
            w_state_next = S_ACC;
          end
        end
      end
      S_ACC: begin
        // A flush here drops the pending accumulate without touching HI/LO.
        w_commit     = ~bus.flush;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Capture the low-half result, its carry and the prepared high operand.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmp_hi <= '0;
      r_tmp_lo <= '0;
      r_tmp_c  <= 1'b0;
    end else if (w_start_acc) begin
      r_tmp_hi <= w_hi_opnd;
      r_tmp_lo <= w_lo_sum[DW-1:0];
      r_tmp_c  <= w_lo_sum[DW];
    end
  end

  // Architectural HI/LO: split writes in IDLE, joint commit out of ACC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hi <= RST_HI;
      r_lo <= RST_LO;
    end else if (w_commit) begin
      r_hi <= w_hi_sum;
      r_lo <= r_tmp_lo;
    end else begin
      if (w_wr_hi) r_hi <= bus.hi_i;
      if (w_wr_lo) r_lo <= bus.lo_i;
    end
  end

  // One-cycle completion pulse following a commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_done <= 1'b0;
    else      r_done <= w_commit;
  end

  assign bus.op_ready = w_ready;
  assign bus.hi_o     = r_hi;
  assign bus.lo_o     = r_lo;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit. A 64-bit reference accumulator models
// {HI,LO}; expected values are queued when an op is driven and popped when
// the DUT should show the result.
module tb_hilo_acc_unit;

  logic clk;
  logic rst;

  hilo_acc_unit_if #(.DW(32)) bus ();

  hilo_acc_unit #(.DW(32), .RST_HI(32'h0), .RST_LO(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] m_acc    = 64'h0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {bus.hi_o, bus.lo_o}, e);
    end
  endtask

  task automatic idle_inputs();
    bus.op_valid = 1'b0;
    bus.op       = 2'b00;
    bus.we_hi    = 1'b0;
    bus.we_lo    = 1'b0;
    bus.hi_i     = '0;
    bus.lo_i     = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic do_write(input logic wh, input logic wl, input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 2'b00;
    bus.we_hi = wh; bus.we_lo = wl; bus.hi_i = h; bus.lo_i = l;
    if (wh) m_acc[63:32] = h;
    if (wl) m_acc[31:0]  = l;
    exp_q.push_back(m_acc);
    @(posedge clk); #1;
    idle_inputs();
    pop_chk("write_hilo");
    chk("write_ready", {63'h0, bus.op_ready}, 64'h1);
    $display("WRITE we_hi=%0b we_lo=%0b hi=%h lo=%h -> hi_o=%h lo_o=%h", wh, wl, h, l, bus.hi_o, bus.lo_o);
  endtask

  task automatic do_acc(input logic sub, input logic [31:0] h, input logic [31:0] l, input logic fl);
    logic [63:0] old;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = sub ? 2'b10 : 2'b01;
    bus.hi_i = h; bus.lo_i = l;
    old = m_acc;
    if (!fl) m_acc = sub ? (old - {h, l}) : (old + {h, l});
    exp_q.push_back(m_acc);
    @(posedge clk); #1;
    idle_inputs();
    chk("acc_busy_ready", {63'h0, bus.op_ready}, 64'h0);
    chk("acc_busy_done", {63'h0, bus.done}, 64'h0);
    chk("acc_no_partial", {bus.hi_o, bus.lo_o}, old);
    @(negedge clk);
    bus.flush = fl;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    pop_chk(fl ? "acc_flushed_hilo" : "acc_commit_hilo");
    chk("acc_done", {63'h0, bus.done}, {63'h0, ~fl});
    chk("acc_ready_back", {63'h0, bus.op_ready}, 64'h1);
    @(posedge clk); #1;
    chk("acc_done_pulse_end", {63'h0, bus.done}, 64'h0);
    $display("ACC sub=%0b opnd=%h%h flush=%0b -> hi_o=%h lo_o=%h", sub, h, l, fl, bus.hi_o, bus.lo_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Asynchronous reset before any clock edge has occurred.
    #2 rst = 1'b0;
    #1;
    chk("rst_async_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
    chk("rst_ready", {63'h0, bus.op_ready}, 64'h1);
    chk("rst_done", {63'h0, bus.done}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    $display("RESET released");

    // Split writes.
    do_write(1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678);
    do_write(1'b0, 1'b1, 32'h11111111, 32'h0000FFFF);
    do_write(1'b0, 1'b0, 32'h22222222, 32'h33333333);

    // Carry out of LO.
    do_write(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
    do_acc(1'b0, 32'h0, 32'h1, 1'b0);

    // Borrow and wrap-around in both directions.
    do_write(1'b1, 1'b1, 32'h0, 32'h0);
    do_acc(1'b1, 32'h0, 32'h1, 1'b0);
    do_acc(1'b0, 32'h0, 32'h1, 1'b0);

    // Mixed patterns.
    do_write(1'b1, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0);
    do_acc(1'b0, 32'h12345678, 32'h9ABCDEF0, 1'b0);
    do_acc(1'b1, 32'h80000000, 32'hF0000001, 1'b0);

    // Flush during ACC discards the accumulate.
    do_write(1'b1, 1'b1, 32'h5, 32'h7);
    do_acc(1'b0, 32'h1, 32'h1, 1'b1);

    // Stall: a WRITE held during ACC is taken only once ready returns.
    do_write(1'b1, 1'b1, 32'h100, 32'h200);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 2'b01; bus.hi_i = 32'h10; bus.lo_i = 32'h20;
    m_acc = m_acc + 64'h00000010_00000020;
    exp_q.push_back(m_acc);
    @(posedge clk); #1;
    chk("stall_busy_ready", {63'h0, bus.op_ready}, 64'h0);
    bus.op = 2'b00; bus.we_hi = 1'b1; bus.we_lo = 1'b0;
    bus.hi_i = 32'hAA; bus.lo_i = 32'h55;
    @(posedge clk); #1;
    pop_chk("stall_commit_hilo");
    chk("stall_commit_done", {63'h0, bus.done}, 64'h1);
    chk("stall_ready_back", {63'h0, bus.op_ready}, 64'h1);
    m_acc[63:32] = 32'hAA;
    exp_q.push_back(m_acc);
    @(posedge clk); #1;
    idle_inputs();
    pop_chk("stall_write_hilo");
    chk("stall_write_done", {63'h0, bus.done}, 64'h0);
    $display("STALL write after acc -> hi_o=%h lo_o=%h", bus.hi_o, bus.lo_o);

    // Flush in IDLE blocks both WRITE and accumulate acceptance.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 2'b00; bus.we_hi = 1'b1; bus.we_lo = 1'b1;
    bus.hi_i = 32'h1234; bus.lo_i = 32'h5678; bus.flush = 1'b1;
    @(posedge clk); #1;
    chk("idle_flush_write", {bus.hi_o, bus.lo_o}, m_acc);
    bus.op = 2'b01;
    @(posedge clk); #1;
    chk("idle_flush_acc_ready", {63'h0, bus.op_ready}, 64'h1);
    idle_inputs();
    @(posedge clk); #1;
    chk("idle_flush_acc_hilo", {bus.hi_o, bus.lo_o}, m_acc);
    chk("idle_flush_acc_done", {63'h0, bus.done}, 64'h0);
    $display("FLUSH idle -> hi_o=%h lo_o=%h", bus.hi_o, bus.lo_o);

    // Reset arriving between acceptance and commit.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 2'b01; bus.hi_i = 32'h3; bus.lo_i = 32'h4;
    @(posedge clk); #1;
    idle_inputs();
    chk("rstacc_busy", {63'h0, bus.op_ready}, 64'h0);
    #2 rst = 1'b0;
    #1;
    m_acc = 64'h0;
    chk("rstacc_hilo", {bus.hi_o, bus.lo_o}, m_acc);
    chk("rstacc_ready", {63'h0, bus.op_ready}, 64'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstacc_no_commit", {bus.hi_o, bus.lo_o}, m_acc);
    chk("rstacc_no_done", {63'h0, bus.done}, 64'h0);
    $display("RESET mid-acc -> hi_o=%h lo_o=%h", bus.hi_o, bus.lo_o);

    // Unit still works after the reset.
    do_acc(1'b0, 32'h1, 32'h2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_acc_unit.md
# hilo_acc_unit

Parametrised HI/LO special-register unit for the MIPS core, replacing the plain HI/LO register pair. It adds split HI/LO writes for MTHI/MTLO and a two-cycle accumulate path for MADD/MSUB-class instructions: {HI,LO} ± a 2·DW product. It adds a ready/valid handshake so the pipeline stalls while an accumulate is in flight, and a flush that cancels an uncommitted accumulate on exception. It sits between the execute/multiply stage (product source) and the register read stage (hi_o/lo_o consumers).

## Interface
- DW, 32, width of each of HI and LO; the accumulator is 2·DW bits.
- RST_HI, 0, reset value of HI (DW bits).
- RST_LO, 0, reset value of LO (DW bits).

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset; asynchronous and active-low.
- op_valid  in  1  operation request this cycle.
- op_ready  out  1  unit can accept an operation; high only in IDLE.
- op  in  2  00 WRITE, 01 ACC_ADD, 10 ACC_SUB, 11 reserved (treated as no-op, but still handshaken).
- we_hi  in  1  WRITE only: update HI from hi_i.
- we_lo  in  1  WRITE only: update LO from lo_i.
- hi_i  in  DW  WRITE data for HI, or upper half of the accumulate operand.
- lo_i  in  DW  WRITE data for LO, or lower half of the accumulate operand.
- flush  in  1  cancels any uncommitted accumulate and blocks acceptance this cycle.
- hi_o  out  DW  architectural HI, registered.
- lo_o  out  DW  architectural LO, registered.
- done  out  1  one-cycle pulse after an accumulate commits.

## Operation
- Accept: an operation is accepted on a rising edge when op_valid & op_ready & ~flush.
- States: IDLE and ACC.
- IDLE, WRITE accepted:
  - HI <= hi_i if we_hi; LO <= lo_i if we_lo.
  - Both, one or neither half may be written.
  - Stay in IDLE.
- IDLE, ACC_ADD/ACC_SUB accepted:
  - lo_sum = LO + (SUB ? ~lo_i : lo_i) + SUB, computed DW+1 bits wide.
  - Latch lo_sum[DW-1:0] into tmp_lo and carry = lo_sum[DW] into tmp_c.
  - Latch (SUB ? ~hi_i : hi_i) into tmp_hi.
  - Go to ACC. HI and LO are not modified yet.
- ACC, no flush:
  - HI <= HI + tmp_hi + tmp_c, truncated to DW bits; LO <= tmp_lo. Both halves commit on the same edge.
  - done <= 1; return to IDLE.
- ACC, flush:
  - Go to IDLE; HI and LO stay unchanged; done stays 0. The accumulate is lost.
- IDLE, flush: any presented op is not accepted and has no effect.
- Arithmetic wraps modulo 2^(2·DW). There is no overflow detection and no trap.
- Signed and unsigned variants are resolved upstream: the operand is already the 2·DW product, so the unit is sign-agnostic.
- In ACC, op_valid and all data inputs are ignored. The requester must hold its request until op_ready is high.

## Timing
- Reset (rst=0, asynchronous):
  - hi_o=RST_HI, lo_o=RST_LO, state=IDLE, done=0, op_ready=1.
  - tmp_* = 0.
  - Reset during ACC discards the accumulate.
- WRITE latency: accepted at edge N, new value visible on hi_o/lo_o after edge N. Back-to-back WRITEs are accepted every cycle.
- Accumulate latency:
  - Accepted at edge N; op_ready=0 for cycle N..N+1.
  - Commit at edge N+1; hi_o/lo_o show the result and done=1 during the cycle after edge N+1.
  - op_ready=1 in that same cycle.
- Accumulate throughput: one per 2 cycles.
- done is registered and lasts exactly one cycle unless another accumulate commits on the next edge, which cannot happen at this throughput.
- hi_o/lo_o never show a half-committed accumulate.
- No combinational path from inputs to hi_o/lo_o/done. op_ready depends only on the state register.

## Test plan
- Reset and split writes:
  - Assert rst=0 mid-cycle → hi_o=0, lo_o=0 immediately, without waiting for a clock edge.
  - Release reset; WRITE we_hi=1, we_lo=0, hi_i=0xDEADBEEF, lo_i=0x12345678 → hi_o=0xDEADBEEF, lo_o=0.
  - Then WRITE we_lo=1 only, lo_i=0x0000FFFF → lo_o=0x0000FFFF, hi_o unchanged.
- Add carry:
  - HI=0, LO=0xFFFFFFFF; ACC_ADD hi_i=0, lo_i=1 → after 2 edges, hi_o=1, lo_o=0, done one-cycle pulse.
  - op_ready=0 for exactly one cycle after acceptance.
- Subtract borrow and wrap:
  - HI=0, LO=0; ACC_SUB hi_i=0, lo_i=1 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFF.
  - Then ACC_ADD hi_i=0, lo_i=1 → both 0 (wrap).
- Flush in ACC:
  - HI=5, LO=7; ACC_ADD hi_i=1, lo_i=1, flush=1 the next cycle → hi_o=5, lo_o=7, done never asserts, op_ready=1 the cycle after.
- Stall handshake:
  - Hold op_valid=1 with WRITE hi_i=0xAA during ACC → WRITE is ignored until op_ready returns, then accepted on exactly one edge.
  - Final hi_o = 0xAA regardless of the accumulated HI.
- Flush in IDLE and reset mid-ACC:
  - op_valid=1, flush=1 in IDLE → no change.
  - ACC_ADD accepted, then rst=0 before commit → outputs return to RST_HI/RST_LO, state IDLE.
